serial_subtractor: RTL and testbench

//  Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a single

---
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// Optional macro: SUB_ADD_MODE_EN adds the op signal (0 = subtract, 1 = add).
//
// Handshake: the master raises start with a/b (and op) valid; the slave samples
// them only while idle (busy=0 and not in its result cycle). busy is high while
// bits are being processed. done pulses for one cycle when diff/bout hold the
// new result; diff/bout then stay stable until the next result is produced.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUB_ADD_MODE_EN
  logic             op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

`ifdef SUB_ADD_MODE_EN
  modport master (output start, a, b, op, input busy, done, diff, bout);
  modport slave  (input start, a, b, op, output busy, done, diff, bout);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b, one bit per clock, LSB first, built from one
// full-adder cell and a carry flop (a + ~b + 1). bout is the borrow (~carry).
// Optional macro: SUB_ADD_MODE_EN adds an op input latched with the operands;
// op=1 selects addition (b not inverted, carry preset 0, bout = carry out).
// dbg_state exposes the FSM state for checkers.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             c;

  // Full-adder cell inputs and outputs for the current bit.
  logic             b_bit;
  logic             s_bit;
  logic             c_next;
  logic             c_preset;
  logic             bout_next;

`ifdef SUB_ADD_MODE_EN
  logic             op_q;

  // In add mode b passes straight through, the carry starts clear and the
  // final carry is reported as-is instead of as a borrow.
  always_comb begin
    b_bit     = op_q ? b_sh[0] : ~b_sh[0];
    c_preset  = ~bus.op;
    bout_next = op_q ? c : ~c;
  end

  // Mode flag is captured together with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      op_q <= bus.op;
    end
  end
`else
  // Subtract only: b is always inverted and the carry starts set.
  always_comb begin
    b_bit     = ~b_sh[0];
    c_preset  = 1'b1;
    bout_next = ~c;
  end
`endif

  // Single full-adder cell.
  always_comb begin
    s_bit  = a_sh[0] ^ b_bit ^ c;
    c_next = (a_sh[0] & b_bit) | (a_sh[0] & c) | (b_bit & c);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; busy is decoded from the state.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Datapath: operand capture, bit-serial shift, and result publication.
  // diff/bout are loaded only when leaving DONE, so they never show partial
  // results; done is registered alongside them so it marks the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      result   <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            cnt  <= '0;
            c    <= c_preset;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= {s_bit, result[WIDTH-1:1]};
          c      <= c_next;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          bus.diff <= result;
          bus.bout <= bout_next;
          bus.done <= 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Optional macro: SUB_ADD_MODE_EN enables the add-mode scenarios.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int LAT   = 6;
  localparam int BUSYN = 4;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  int errors;
  int checks;

  logic [WIDTH:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sif),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic, result packed as {bout, diff}.
  function automatic logic [WIDTH:0] ref_calc(input int av, input int bv, input bit add);
    int r;
    logic [WIDTH:0] v;
    if (add) begin
      r = av + bv;
      v = {(r >= (1 << WIDTH)), WIDTH'(r % (1 << WIDTH))};
    end else begin
      r = av - bv;
      if (r < 0) r = r + (1 << WIDTH);
      v = {(av < bv), WIDTH'(r)};
    end
    return v;
  endfunction

  task automatic set_op(input bit opi);
`ifdef SUB_ADD_MODE_EN
    sif.op = opi;
`else
    if (opi) $display("note: add mode not built");
`endif
  endtask

  // Driver: one operation, start for one cycle, operands scrambled after accept.
  // Returns observed result, latency in cycles (-1 on timeout) and busy count.
  task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input bit opi, output logic [WIDTH-1:0] d, output logic bo,
                        output int lat, output int busy_n);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = ai;
    sif.b     = bi;
    set_op(opi);
    exp_q.push_back(ref_calc(int'(ai), int'(bi), opi));
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = WIDTH'($urandom);
    sif.b     = WIDTH'($urandom);
    lat    = 1;
    busy_n = sif.busy ? 1 : 0;
    while (!sif.done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (sif.busy) busy_n++;
    end
    if (!sif.done) lat = -1;
    d  = sif.diff;
    bo = sif.bout;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    set_op(1'b0);
    #12;
    checks++;
    if ({sif.busy, sif.done, sif.bout, sif.diff} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b bout=%b diff=%h want all 0",
               sif.busy, sif.done, sif.bout, sif.diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", sif.busy, sif.done);
    end
  endtask

  // Directed vectors including the extremes of the operand range.
  task automatic test_directed();
    logic [WIDTH-1:0] av[6] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0, 4'd15};
    logic [WIDTH-1:0] bv[6] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd15, 4'd0};
    logic [WIDTH-1:0] d;
    logic bo;
    int lat, bn;
    logic [WIDTH:0] e;
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], 1'b0, d, bo, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if ({bo, d} !== e) begin
        errors++;
        $display("FAIL directed_%0d got bout=%b diff=%h want bout=%b diff=%h",
                 i, bo, d, e[WIDTH], e[WIDTH-1:0]);
      end
      checks++;
      if (lat !== LAT || bn !== BUSYN) begin
        errors++;
        $display("FAIL timing_%0d got latency=%0d busy=%0d want %0d %0d",
                 i, lat, bn, LAT, BUSYN);
      end
    end
  endtask

  // start asserted during RUN and DONE must not restart or alter the result.
  task automatic test_ignore_start();
    int dones;
    logic [WIDTH:0] e;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = 4'd9;
    sif.b = 4'd3;
    set_op(1'b0);
    e = ref_calc(9, 3, 1'b0);
    @(posedge clk);
    dones = 0;
    @(negedge clk);
    sif.a = 4'd1;
    sif.b = 4'd1;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (i == 5) sif.start = 1'b0;
      if (sif.done) begin
        dones++;
        checks++;
        if ({sif.bout, sif.diff} !== e) begin
          errors++;
          $display("FAIL ignore_start_result got bout=%b diff=%h want bout=%b diff=%h",
                   sif.bout, sif.diff, e[WIDTH], e[WIDTH-1:0]);
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start_dones got %0d want 1", dones);
    end
  endtask

  // Reset in the middle of RUN aborts with no done; then a clean operation.
  task automatic test_reset_mid_run();
    int dones;
    logic [WIDTH-1:0] d;
    logic bo;
    int lat, bn;
    logic [WIDTH:0] e;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = 4'd9;
    sif.b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sif.busy, sif.done, sif.bout, sif.diff} !== 7'b0) begin
      errors++;
      $display("FAIL mid_run_reset got busy=%b done=%b bout=%b diff=%h want all 0",
               sif.busy, sif.done, sif.bout, sif.diff);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (sif.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_run_no_done got %0d done pulses want 0", dones);
    end
    run_op(4'd5, 4'd2, 1'b0, d, bo, lat, bn);
    e = exp_q.pop_front();
    checks++;
    if ({bo, d} !== e || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset got bout=%b diff=%h lat=%0d want bout=%b diff=%h lat=%0d",
               bo, d, lat, e[WIDTH], e[WIDTH-1:0], LAT);
    end
  endtask

  // start held high: two operations with one idle cycle between them.
  task automatic test_back_to_back();
    int t_done[$];
    logic [WIDTH:0] got[$];
    logic [WIDTH:0] e;
    logic [WIDTH-1:0] a1, b1, a2, b2;
    a1 = WIDTH'($urandom_range(0, 15));
    b1 = WIDTH'($urandom_range(0, 15));
    a2 = WIDTH'($urandom_range(0, 15));
    b2 = WIDTH'($urandom_range(0, 15));
    exp_q.push_back(ref_calc(int'(a1), int'(b1), 1'b0));
    exp_q.push_back(ref_calc(int'(a2), int'(b2), 1'b0));
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = a1;
    sif.b = b1;
    set_op(1'b0);
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        sif.a = a2;
        sif.b = b2;
      end
      if (i == 7) sif.start = 1'b0;
      if (sif.done) begin
        t_done.push_back(i);
        got.push_back({sif.bout, sif.diff});
      end
    end
    checks++;
    if (t_done.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count got %0d done pulses want 2", t_done.size());
    end else begin
      checks++;
      if (t_done[0] !== LAT || t_done[1] !== 2 * LAT) begin
        errors++;
        $display("FAIL b2b_timing got done at %0d,%0d want %0d,%0d",
                 t_done[0], t_done[1], LAT, 2 * LAT);
      end
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (k >= got.size() || got[k] !== e) begin
        errors++;
        $display("FAIL b2b_result_%0d got %h want %h", k,
                 (k < got.size()) ? got[k] : '0, e);
      end
    end
  endtask

  // Randomized operations against the reference model.
  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic bo;
    int lat, bn;
    bit opi;
    logic [WIDTH:0] e;
    for (int i = 0; i < 30; i++) begin
`ifdef SUB_ADD_MODE_EN
      opi = 1'($urandom_range(0, 1));
`else
      opi = 1'b0;
`endif
      run_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), opi,
             d, bo, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if ({bo, d} !== e || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d op=%0d got bout=%b diff=%h lat=%0d want bout=%b diff=%h lat=%0d",
                 i, opi, bo, d, lat, e[WIDTH], e[WIDTH-1:0], LAT);
      end
    end
  endtask

`ifdef SUB_ADD_MODE_EN
  task automatic test_add_mode();
    logic [WIDTH-1:0] av[3] = '{4'd7, 4'd2, 4'd15};
    logic [WIDTH-1:0] bv[3] = '{4'd9, 4'd3, 4'd15};
    logic [WIDTH-1:0] d;
    logic bo;
    int lat, bn;
    logic [WIDTH:0] e;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 1'b1, d, bo, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if ({bo, d} !== e) begin
        errors++;
        $display("FAIL add_%0d got bout=%b diff=%h want bout=%b diff=%h",
                 i, bo, d, e[WIDTH], e[WIDTH-1:0]);
      end
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SUB_ADD_MODE_EN
    test_add_mode();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
